// File: rtl/circuito_simple_pkg.sv
// Shared constants and types for the delayed three-gate circuit.
// Default gate latencies are in clock cycles.
package circuito_simple_pkg;

    localparam int AND_DLY_DEF = 3;
    localparam int NOT_DLY_DEF = 1;
    localparam int OR_DLY_DEF  = 2;

    typedef logic gate_val_t;

endpackage

// File: rtl/circuito_simple_con_retardo_de_prop_gate_delay_line.sv
// Per-gate delay line: transport shift register, or an inertial filter
// when GATE_INERTIAL_DLY_EN is defined.
module gate_delay_line
    import circuito_simple_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic stable
);

`ifdef GATE_INERTIAL_DLY_EN
    localparam int CW = $clog2(DEPTH + 1);

    gate_val_t       r_last;
    gate_val_t       r_out;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    // Count consecutive samples of the same value, saturating at DEPTH.
    always_comb begin
        w_cnt_nxt = CW'(1);
        if (din == r_last) begin
            w_cnt_nxt = (r_cnt == CW'(DEPTH)) ? r_cnt : r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b0;
            r_out  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_last <= din;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == CW'(DEPTH)) begin
                r_out <= din;
            end
        end
    end

    assign dout   = r_out;
    assign stable = (r_out == din) && (r_last == din);
`else
    logic [DEPTH-1:0] r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign dout   = r_sr[DEPTH-1];
    assign stable = (r_sr == {DEPTH{din}});
`endif

endmodule

// File: rtl/circuito_simple_con_retardo_de_prop.sv
// D = (A & B) | ~C, E = ~C with per-gate cycle delays (transport by
// default, inertial with GATE_INERTIAL_DLY_EN).
module circuito_simple_con_retardo_de_prop
    import circuito_simple_pkg::*;
#(
    parameter int AND_DLY = AND_DLY_DEF,
    parameter int NOT_DLY = NOT_DLY_DEF,
    parameter int OR_DLY  = OR_DLY_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic e,
    output logic settled
);

    gate_val_t w_g1_in;
    gate_val_t w_g2_in;
    gate_val_t w_g3_in;
    gate_val_t w_w1;
    gate_val_t w_e;
    gate_val_t w_d;
    logic      w_st1;
    logic      w_st2;
    logic      w_st3;

    assign w_g1_in = a & b;
    assign w_g2_in = ~c;
    // The OR gate sees the delayed outputs of G1 and G2.
    assign w_g3_in = w_w1 | w_e;

    gate_delay_line #(.DEPTH(AND_DLY)) u_g1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (w_g1_in),
        .dout   (w_w1),
        .stable (w_st1)
    );

    gate_delay_line #(.DEPTH(NOT_DLY)) u_g2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (w_g2_in),
        .dout   (w_e),
        .stable (w_st2)
    );

    gate_delay_line #(.DEPTH(OR_DLY)) u_g3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (w_g3_in),
        .dout   (w_d),
        .stable (w_st3)
    );

    assign d       = w_d;
    assign e       = w_e;
    assign settled = w_st1 & w_st2 & w_st3;

endmodule

// File: tb/tb_circuito_simple_con_retardo_de_prop.sv
// Directed bench for the delayed three-gate circuit (default build).
module tb_circuito_simple_con_retardo_de_prop;

    logic clk = 1'b0;
    logic rst_n;
    logic a, b, c;
    logic d, e, settled;
    logic a2, b2, c2;
    logic d2, e2, settled2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    circuito_simple_con_retardo_de_prop dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .e       (e),
        .settled (settled)
    );

    circuito_simple_con_retardo_de_prop #(
        .AND_DLY (1),
        .NOT_DLY (2),
        .OR_DLY  (1)
    ) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a2),
        .b       (b2),
        .c       (c2),
        .d       (d2),
        .e       (e2),
        .settled (settled2)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a = 0; b = 0; c = 0;
        a2 = 1; b2 = 1; c2 = 0;

        // Reset state
        tick(2);
        chk("rst_d", d, 1'b0);
        chk("rst_e", e, 1'b0);
        chk("rst_settled", settled, 1'b0);
        rst_n = 1'b1;

        // Power-up settling from a=b=c=0
        tick(1);
        chk("up_e1", e, 1'b1);
        chk("up_d1", d, 1'b0);
        tick(1);
        chk("up_d2", d, 1'b0);
        chk("up_st2", settled, 1'b0);
        tick(1);
        chk("up_d3", d, 1'b1);
        chk("up_st3", settled, 1'b1);

        // Hazard: a,b,c all rise together
        a = 1; b = 1; c = 1;
        tick(1);
        chk("hz_e1", e, 1'b0);
        chk("hz_d1", d, 1'b1);
        tick(1);
        chk("hz_d2", d, 1'b1);
        tick(1);
        chk("hz_d3", d, 1'b0);
        tick(1);
        chk("hz_d4", d, 1'b0);
        chk("hz_st4", settled, 1'b0);
        tick(1);
        chk("hz_d5", d, 1'b1);
        chk("hz_st5", settled, 1'b1);

        // a=b=1: c 0 -> 1, w1 keeps d high
        c = 0;
        tick(6);
        chk("ab_e0", e, 1'b1);
        chk("ab_st0", settled, 1'b1);
        c = 1;
        tick(1);
        chk("ab_e1", e, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("ab_d%0d", i), d, 1'b1);
            if (i < 5) tick(1);
        end

        // One-cycle a=b pulse with c=1 passes through transport delay
        a = 0; b = 0;
        tick(8);
        chk("pl_d0", d, 1'b0);
        chk("pl_st0", settled, 1'b1);
        a = 1; b = 1;
        tick(1);
        a = 0; b = 0;
        chk("pl_d1", d, 1'b0);
        for (int i = 2; i <= 7; i++) begin
            tick(1);
            chk($sformatf("pl_d%0d", i), d, (i == 5) ? 1'b1 : 1'b0);
        end

        // Reset during an in-flight c transition
        c = 0;
        tick(2);
        chk("mr_e2", e, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_e_rst", e, 1'b0);
        chk("mr_d_rst", d, 1'b0);
        chk("mr_st_rst", settled, 1'b0);
        tick(2);
        chk("mr_d_hold", d, 1'b0);
        rst_n = 1'b1;
        tick(1);
        chk("mr_e1", e, 1'b1);
        chk("mr_d1", d, 1'b0);
        tick(1);
        chk("mr_d2", d, 1'b0);
        tick(1);
        chk("mr_d3", d, 1'b1);
        chk("mr_st3", settled, 1'b1);

        // Overridden delays: AND=1, NOT=2, OR=1
        chk("ov_st0", settled2, 1'b1);
        chk("ov_e0", e2, 1'b1);
        c2 = 1;
        tick(1);
        chk("ov_e1", e2, 1'b1);
        chk("ov_d1", d2, 1'b1);
        tick(1);
        chk("ov_e2", e2, 1'b0);
        chk("ov_d2", d2, 1'b1);
        tick(1);
        chk("ov_d3", d2, 1'b1);
        chk("ov_st3", settled2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
